// File: rtl/stoch_signed_window_decoder_pkg.sv
// Shared types and helpers for the signed stochastic window decoder:
// FSM state encoding, accumulator width rule and the per-sample increment.
package stoch_decode_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_ACCUM  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // One guard bit above the window size plus a sign bit covers -2^W..+2^W.
    function automatic int acc_w(input int window_log2);
        return window_log2 + 2;
    endfunction

    // Signed increment of one bitstream pair: (1,0)->+1, (0,1)->-1, else 0.
    function automatic logic signed [1:0] signed_inc(input logic x_p, input logic x_m);
        return {~x_p & x_m, x_p ^ x_m};
    endfunction

endpackage

// File: rtl/stoch_signed_window_decoder_if.sv
// Sample/result bus of the window decoder; master is the producer/consumer side.
interface stoch_signed_window_decoder_if
    import stoch_decode_pkg::*;
#(
    parameter int NUM_CH      = 27,
    parameter int WINDOW_LOG2 = 8
);
    localparam int ACC_W = acc_w(WINDOW_LOG2);

    logic                           start;
    logic                           in_valid;
    logic [NUM_CH-1:0]              x_p;
    logic [NUM_CH-1:0]              x_m;
    logic                           busy;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_CH-1:0][ACC_W-1:0]   y;

    modport master (
        output start, in_valid, x_p, x_m, out_ready,
        input  busy, out_valid, y
    );

    modport slave (
        input  start, in_valid, x_p, x_m, out_ready,
        output busy, out_valid, y
    );

endinterface

// File: rtl/stoch_signed_acc.sv
// Per-channel signed up/down counter for one (x_p, x_m) bitstream pair.
module stoch_signed_acc
    import stoch_decode_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic                    CLK,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    x_p,
    input  logic                    x_m,
    output logic signed [ACC_W-1:0] acc
);
    localparam int LIM = 2 ** (ACC_W - 2);

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [1:0]       inc;

    assign inc = signed_inc(x_p, x_m);
    assign acc = acc_reg;

    // Clear wins over enable so a new window never inherits a stray sample.
    always_ff @(posedge CLK) begin
        if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + {{(ACC_W-2){inc[1]}}, inc};
        end
    end

    acc_in_range: assert property (@(posedge CLK)
        int'(acc_reg) <= LIM && int'(acc_reg) >= -LIM);

endmodule

// File: rtl/stoch_signed_window_decoder.sv
// Integrates NUM_CH signed bitstream pairs over 2^WINDOW_LOG2 accepted samples
// and hands the per-channel counts out through a valid/ready handshake.
module stoch_signed_window_decoder
    import stoch_decode_pkg::*;
#(
    parameter int NUM_CH      = 27,
    parameter int WINDOW_LOG2 = 8,
    parameter int WARMUP      = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    stoch_signed_window_decoder_if.slave  bus
);
    localparam int ACC_W = acc_w(WINDOW_LOG2);
    localparam logic [3:0] WARM_INIT = 4'(WARMUP);

    state_t                  state_reg, state_next;
    logic [WINDOW_LOG2-1:0]  cnt_reg, cnt_next;
    logic [3:0]              warm_cnt_reg, warm_cnt_next;
    logic                    acc_clr;
    logic                    acc_en;
    logic                    launch;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            warm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            warm_cnt_reg <= warm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        warm_cnt_next = warm_cnt_reg;
        acc_clr       = 1'b0;
        acc_en        = 1'b0;
        launch        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                launch = bus.start;
            end
            S_WARMUP: begin
                if (bus.in_valid) begin
                    warm_cnt_next = warm_cnt_reg - 4'd1;
                    if (warm_cnt_reg == 4'd1) begin
                        state_next = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_en   = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (&cnt_reg) begin
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        launch = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A new window (from IDLE or back-to-back from HOLD) starts from zero.
        if (launch) begin
            acc_clr       = 1'b1;
            cnt_next      = '0;
            warm_cnt_next = WARM_INIT;
            state_next    = (WARMUP > 0) ? S_WARMUP : S_ACCUM;
        end
    end

    assign bus.busy      = (state_reg == S_WARMUP) || (state_reg == S_ACCUM);
    assign bus.out_valid = (state_reg == S_HOLD);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [ACC_W-1:0] acc_ch;

            stoch_signed_acc #(
                .ACC_W (ACC_W)
            ) u_acc (
                .CLK (CLK),
                .clr (acc_clr | RST),
                .en  (acc_en),
                .x_p (bus.x_p[gi]),
                .x_m (bus.x_m[gi]),
                .acc (acc_ch)
            );

            assign bus.y[gi] = acc_ch;
        end
    endgenerate

endmodule
